line_stepper: RTL and testbench

- Bresenham pixel generator. It consumes a captured line descriptor in the same 44-bit line capture register format the rasterizer front end produces, and emits one pixel coordinate per cycle along the line.
- It recomputes deltas, step directions and the steep/shallow decision internally.
- It sits between the line capture stage and the framebuffer write stage.
- Flow control is a valid/ready handshake on both sides.

---
 rtl/line_stepper.sv | 195 +++++++++++++++++++
 tb/tb_line_stepper.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_stepper.sv
// line_stepper: Bresenham pixel generator.
// Takes a 44-bit line descriptor {x0, y0, x1, y1, attr} over a valid/ready
// handshake. It emits one pixel per cycle from (x0,y0) to (x1,y1) on a second
// valid/ready handshake. px_last marks the final pixel, and line_done pulses
// in the same cycle as the final handshake.
// Optional feature macro: LINE_CLIP_EN. When it is defined, pixels outside
// H_RES x V_RES are dropped without waiting on px_ready.
module line_stepper #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [43:0] line_cap_reg,
  input  logic        line_valid,
  output logic        line_ready,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [3:0]  px_attr,
  output logic        px_valid,
  input  logic        px_ready,
  output logic        px_last,
  output logic        line_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    STEP  = 2'd2
  } state_t;

  state_t      state_q;

  // Captured descriptor and derived direction and magnitude information
  logic [9:0]  x0_q, y0_q;
  logic [9:0]  adx_q, ady_q;
  logic        sx_neg_q, sy_neg_q;
  logic        steep_q;

  // Bresenham working state
  logic [9:0]  maj_q, min_q;
  logic [12:0] err_q;
  logic [9:0]  cnt_q;

  // Registered pixel outputs. px_x/px_y also serve as the current pixel.
  logic [9:0]  px_x_q, px_y_q;
  logic [3:0]  px_attr_q;
  logic        px_valid_q;
  logic        px_last_q;

  // Descriptor field decode
  logic [9:0]  cap_x0, cap_y0, cap_x1, cap_y1;
  logic [3:0]  cap_attr;
  logic        cap_dx_neg, cap_dy_neg;
  logic [9:0]  cap_adx, cap_ady;

  assign cap_x0   = line_cap_reg[43:34];
  assign cap_y0   = line_cap_reg[33:24];
  assign cap_x1   = line_cap_reg[23:14];
  assign cap_y1   = line_cap_reg[13:4];
  assign cap_attr = line_cap_reg[3:0];

  // The sign of the 11-bit difference is just an unsigned compare. The
  // magnitude is then a 10-bit subtract in the non-negative direction.
  assign cap_dx_neg = (cap_x1 < cap_x0);
  assign cap_dy_neg = (cap_y1 < cap_y0);
  assign cap_adx    = cap_dx_neg ? (cap_x0 - cap_x1) : (cap_x1 - cap_x0);
  assign cap_ady    = cap_dy_neg ? (cap_y0 - cap_y1) : (cap_y1 - cap_y0);

  // SETUP arithmetic: select the major and minor axes, then seed the error term
  logic [9:0]  maj_s, min_s;
  logic [12:0] err_init;

  assign maj_s    = steep_q ? ady_q : adx_q;
  assign min_s    = steep_q ? adx_q : ady_q;
  assign err_init = {2'b00, min_s, 1'b0} - {3'b000, maj_s};

  // STEP arithmetic: the candidate next pixel and the next error term
  logic        err_pos;
  logic [9:0]  step_x, step_y;
  logic [9:0]  next_x, next_y;
  logic [12:0] two_min, two_maj;
  logic [12:0] err_next;
  logic        advance;

  assign err_pos  = !err_q[12] && (err_q != 13'd0);
  assign step_x   = px_x_q + (sx_neg_q ? 10'h3FF : 10'h001);
  assign step_y   = px_y_q + (sy_neg_q ? 10'h3FF : 10'h001);
  // The major axis always steps. The minor axis steps only when err > 0.
  assign next_x   = (!steep_q || err_pos) ? step_x : px_x_q;
  assign next_y   = (steep_q || err_pos) ? step_y : px_y_q;
  assign two_min  = {2'b00, min_q, 1'b0};
  assign two_maj  = {2'b00, maj_q, 1'b0};
  assign err_next = err_pos ? (err_q + two_min - two_maj) : (err_q + two_min);

  // A pixel retires on a handshake, or immediately when it was dropped (never
  // valid). Without clipping, px_valid is always high in STEP.
  assign advance = (state_q == STEP) && (!px_valid_q || px_ready);

  // On-screen tests for the pixel loaded in SETUP and for the next pixel in STEP
  logic setup_vis, step_vis;

`ifdef LINE_CLIP_EN
  assign setup_vis = ({22'd0, x0_q} < H_RES) && ({22'd0, y0_q} < V_RES);
  assign step_vis  = ({22'd0, next_x} < H_RES) && ({22'd0, next_y} < V_RES);
`else
  assign setup_vis = 1'b1;
  assign step_vis  = 1'b1;
  logic unused_params;
  assign unused_params = (H_RES > 0) ^ (V_RES > 0);
`endif

  assign line_ready = (state_q == IDLE);
  assign px_x       = px_x_q;
  assign px_y       = px_y_q;
  assign px_attr    = px_attr_q;
  assign px_valid   = px_valid_q;
  assign px_last    = px_last_q;
  // Pulse in the same cycle as the retirement of the final pixel.
  assign line_done  = advance && (cnt_q == 10'd0);

  // Line FSM: capture the descriptor, seed Bresenham, then walk the pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      adx_q      <= '0;
      ady_q      <= '0;
      sx_neg_q   <= 1'b0;
      sy_neg_q   <= 1'b0;
      steep_q    <= 1'b0;
      maj_q      <= '0;
      min_q      <= '0;
      err_q      <= '0;
      cnt_q      <= '0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_attr_q  <= '0;
      px_valid_q <= 1'b0;
      px_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          px_valid_q <= 1'b0;
          px_last_q  <= 1'b0;
          if (line_valid) begin
            x0_q      <= cap_x0;
            y0_q      <= cap_y0;
            px_attr_q <= cap_attr;
            adx_q     <= cap_adx;
            ady_q     <= cap_ady;
            sx_neg_q  <= cap_dx_neg;
            sy_neg_q  <= cap_dy_neg;
            steep_q   <= (cap_ady > cap_adx);
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          maj_q      <= maj_s;
          min_q      <= min_s;
          err_q      <= err_init;
          cnt_q      <= maj_s;
          px_x_q     <= x0_q;
          px_y_q     <= y0_q;
          px_valid_q <= setup_vis;
          px_last_q  <= setup_vis && (maj_s == 10'd0);
          state_q    <= STEP;
        end
        STEP: begin
          if (advance) begin
            if (cnt_q == 10'd0) begin
              px_valid_q <= 1'b0;
              px_last_q  <= 1'b0;
              state_q    <= IDLE;
            end else begin
              px_x_q     <= next_x;
              px_y_q     <= next_y;
              err_q      <= err_next;
              cnt_q      <= cnt_q - 10'd1;
              px_valid_q <= step_vis;
              px_last_q  <= step_vis && (cnt_q == 10'd1);
            end
          end
        end
        default: begin
          px_valid_q <= 1'b0;
          px_last_q  <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_stepper.sv
// Directed testbench for line_stepper.
// A table of lines with hand-computed pixel lists is replayed with px_ready
// held high. Hand-written sequences cover backpressure, reset in mid-line and,
// when LINE_CLIP_EN is defined, off-screen clipping.
module tb_line_stepper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [43:0] line_cap_reg;
  logic        line_valid;
  logic        line_ready;
  logic [9:0]  px_x, px_y;
  logic [3:0]  px_attr;
  logic        px_valid;
  logic        px_ready;
  logic        px_last;
  logic        line_done;

  always #5 clk = ~clk;

  line_stepper dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_cap_reg (line_cap_reg),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .px_x         (px_x),
    .px_y         (px_y),
    .px_attr      (px_attr),
    .px_valid     (px_valid),
    .px_ready     (px_ready),
    .px_last      (px_last),
    .line_done    (line_done)
  );

  typedef struct packed {
    logic [9:0] x0;
    logic [9:0] y0;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [3:0] attr;
    logic [7:0] first;
    logic [7:0] npix;
  } vec_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pix_t;

  vec_t vecs [16];
  pix_t pix_tab [64];
  int   n_vecs = 0;
  int   n_pix  = 0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic add_line(input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1,
                          input logic [3:0] attr);
    vecs[n_vecs] = {x0, y0, x1, y1, attr, 8'(n_pix), 8'd0};
    n_vecs++;
  endtask

  task automatic add_pix(input logic [9:0] x, input logic [9:0] y);
    pix_tab[n_pix] = {x, y};
    n_pix++;
    vecs[n_vecs-1].npix = vecs[n_vecs-1].npix + 8'd1;
  endtask

  // Present a descriptor, let it be accepted, and check the SETUP bubble
  task automatic accept(input logic [9:0] x0, input logic [9:0] y0,
                        input logic [9:0] x1, input logic [9:0] y1,
                        input logic [3:0] attr);
    @(negedge clk);
    line_cap_reg = {x0, y0, x1, y1, attr};
    line_valid   = 1'b1;
    #1;
    check("line_ready_idle", 32'(line_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    line_valid = 1'b0;
    check("setup_no_valid", 32'(px_valid), 32'd0);
    check("setup_not_ready", 32'(line_ready), 32'd0);
  endtask

  // Replay one table line with px_ready held high
  task automatic run_line(input int vi);
    vec_t v;
    pix_t p;
    logic last;
    v = vecs[vi];
    px_ready = 1'b1;
    accept(v.x0, v.y0, v.x1, v.y1, v.attr);
    for (int k = 0; k < int'(v.npix); k++) begin
      @(posedge clk);
      @(negedge clk);
      p    = pix_tab[int'(v.first) + k];
      last = (k == int'(v.npix) - 1);
      $display("line %0d pixel %0d: (%0d,%0d) attr=%0h last=%0b done=%0b",
               vi, k, px_x, px_y, px_attr, px_last, line_done);
      check("px_valid", 32'(px_valid), 32'd1);
      check("px_xy", 32'({px_x, px_y}), 32'(p));
      check("px_attr", 32'(px_attr), 32'(v.attr));
      check("px_last", 32'(px_last), 32'(last));
      check("line_done", 32'(line_done), 32'(last));
      check("step_not_ready", 32'(line_ready), 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    check("ready_after_line", 32'(line_ready), 32'd1);
    check("valid_after_line", 32'(px_valid), 32'd0);
    check("done_after_line", 32'(line_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  pat;
    logic [19:0] held;
    int          got;
    bit          stalled;
    bit          done;
    int          reset_vi;

    // Expected pixel lists, worked out by hand from the Bresenham recurrence
    add_line(10'd0, 10'd0, 10'd4, 10'd2, 4'hA);      // shallow
    add_pix(0, 0); add_pix(1, 0); add_pix(2, 1); add_pix(3, 1); add_pix(4, 2);
    add_line(10'd5, 10'd10, 10'd3, 10'd4, 4'h3);     // steep, both negative
    add_pix(5, 10); add_pix(5, 9); add_pix(4, 8); add_pix(4, 7);
    add_pix(4, 6); add_pix(3, 5); add_pix(3, 4);
    add_line(10'd100, 10'd200, 10'd100, 10'd200, 4'h5); // degenerate
    add_pix(100, 200);
    add_line(10'd10, 10'd10, 10'd13, 10'd7, 4'hF);   // 45 degrees, y down
    add_pix(10, 10); add_pix(11, 9); add_pix(12, 8); add_pix(13, 7);
    add_line(10'd7, 10'd3, 10'd4, 10'd3, 4'h1);      // horizontal, x down
    add_pix(7, 3); add_pix(6, 3); add_pix(5, 3); add_pix(4, 3);
    add_line(10'd2, 10'd0, 10'd2, 10'd2, 4'h4);      // vertical
    add_pix(2, 0); add_pix(2, 1); add_pix(2, 2);
    add_line(10'd639, 10'd479, 10'd637, 10'd478, 4'h7); // screen corner
    add_pix(639, 479); add_pix(638, 479); add_pix(637, 478);
    reset_vi = n_vecs;
    add_line(10'd1, 10'd1, 10'd2, 10'd1, 4'h6);      // line after reset
    add_pix(1, 1); add_pix(2, 1);

    rst_n        = 1'b0;
    line_valid   = 1'b0;
    line_cap_reg = '0;
    px_ready     = 1'b0;
    #1;
    check("rst_px_valid", 32'(px_valid), 32'd0);
    check("rst_px_xy", 32'({px_x, px_y}), 32'd0);
    check("rst_px_attr", 32'(px_attr), 32'd0);
    check("rst_px_last", 32'(px_last), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_line_ready", 32'(line_ready), 32'd1);

    for (int i = 0; i < n_vecs; i++) begin
      run_line(i);
    end

    // Backpressure on (0,0)->(3,0) with px_ready cycling 1,0,0,1
    pat = 4'b1001;
    px_ready = 1'b1;
    accept(10'd0, 10'd0, 10'd3, 10'd0, 4'h2);
    got = 0;
    stalled = 1'b0;
    done = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      @(negedge clk);
      px_ready = pat[c % 4];
      #1;
      if (stalled) check("bp_stall_hold", 32'({px_x, px_y}), 32'(held));
      if (px_valid && px_ready) begin
        $display("backpressure pixel %0d: (%0d,%0d) last=%0b done=%0b",
                 got, px_x, px_y, px_last, line_done);
        check("bp_xy", 32'({px_x, px_y}), 32'({10'(got), 10'd0}));
        check("bp_last", 32'(px_last), 32'(got == 3));
        check("bp_done", 32'(line_done), 32'(got == 3));
        if (px_last || got >= 3) done = 1'b1;
        got++;
        stalled = 1'b0;
      end else begin
        check("bp_done_stalled", 32'(line_done), 32'd0);
        stalled = px_valid;
        held    = {px_x, px_y};
      end
    end
    check("bp_count", 32'(got), 32'd4);
    px_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after", 32'(line_ready), 32'd1);
    check("bp_valid_after", 32'(px_valid), 32'd0);

    // Reset in the middle of (0,0)->(9,9), after three pixels have retired
    accept(10'd0, 10'd0, 10'd9, 10'd9, 4'hC);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      $display("pre-reset pixel %0d: (%0d,%0d)", k, px_x, px_y);
      check("mid_xy", 32'({px_x, px_y}), 32'({10'(k), 10'(k)}));
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    $display("reset asserted mid-line: valid=%0b xy=(%0d,%0d)", px_valid, px_x, px_y);
    check("mrst_px_valid", 32'(px_valid), 32'd0);
    check("mrst_px_xy", 32'({px_x, px_y}), 32'd0);
    check("mrst_px_attr", 32'(px_attr), 32'd0);
    check("mrst_px_last", 32'(px_last), 32'd0);
    check("mrst_line_done", 32'(line_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mrst_no_done", 32'(line_done), 32'd0);
      check("mrst_no_valid", 32'(px_valid), 32'd0);
    end
    run_line(reset_vi);

`ifdef LINE_CLIP_EN
    // (638,0)->(643,0) leaves the screen after x=639
    begin
      int nv;
      int ndone;
      int nlast;
      nv = 0;
      ndone = 0;
      nlast = 0;
      px_ready = 1'b1;
      accept(10'd638, 10'd0, 10'd643, 10'd0, 4'h9);
      for (int c = 0; c < 20 && ndone == 0; c++) begin
        @(posedge clk);
        @(negedge clk);
        if (px_valid) begin
          $display("clip pixel %0d: (%0d,%0d) last=%0b", nv, px_x, px_y, px_last);
          check("clip_xy", 32'({px_x, px_y}), 32'({10'(638 + nv), 10'd0}));
          nv++;
        end
        if (px_last) nlast++;
        if (line_done) ndone++;
      end
      check("clip_visible_count", 32'(nv), 32'd2);
      check("clip_no_last", 32'(nlast), 32'd0);
      check("clip_done", 32'(ndone), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("clip_ready_after", 32'(line_ready), 32'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
